// File: rtl/axis_noc_tx_bridge_pkg.sv
// Shared definitions for the AXIS-to-NoC transmit bridge.
// Contents: default widths, flit layout structs at the default widths, the
// bridge FSM state enum and the VC select width helper.
package axis_noc_tx_bridge_pkg;

    localparam int DEFAULT_D_W           = 32;
    localparam int DEFAULT_A_W           = 4;
    localparam int DEFAULT_VC_W          = 2;
    localparam int DEFAULT_TDEST_W       = 8;
    localparam int DEFAULT_TID_W         = 8;
    localparam int DEFAULT_VC_FIFO_DEPTH = 64;

    // A single-VC build still carries a 1-bit select so index vectors never
    // collapse to zero width.
    localparam int VC_SEL_W = (DEFAULT_VC_W > 1) ? $clog2(DEFAULT_VC_W) : 1;

    function automatic int vc_sel_width(input int vc_w);
        return (vc_w > 1) ? $clog2(vc_w) : 1;
    endfunction

    typedef struct packed {
        logic [DEFAULT_D_W-1:0] data;
        logic                   last;
    } noc_payload_s;

    typedef struct packed {
        logic [DEFAULT_A_W-1:0] addr;
    } noc_routeinfo_s;

    typedef struct packed {
        noc_payload_s   payload;
        noc_routeinfo_s routeinfo;
    } noc_packet_s;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DROP  = 2'd2
    } bridge_state_e;

endpackage

// File: rtl/noc_credit_counter.sv
// Credit counter for one virtual channel of the downstream RX FIFO.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   inc         credit returned this cycle
//   dec         flit sent this cycle
//   nonzero     at least one credit available (registered count)
//   ovf         sticky: a credit arrived while the counter was already full
module noc_credit_counter #(
    parameter int DEPTH = 64,
    parameter int CW    = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic nonzero,
    output logic ovf
);

    localparam logic [CW-1:0] MAX_CNT = CW'(DEPTH - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= MAX_CNT;
            ovf   <= 1'b0;
        end else if (inc && !dec) begin
            if (count == MAX_CNT) begin
                ovf <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end else if (dec && !inc) begin
            count <= count - 1'b1;
        end
    end

    assign nonzero = (count != '0);

endmodule

// File: rtl/axis_noc_tx_bridge.sv
// AXI-Stream to NoC ingress bridge. Each accepted beat becomes one flit
// {data, last, addr} on the VC chosen by tid at packet start, gated by
// per-VC credits for the downstream RX FIFOs.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   s_axis_*         AXIS slave (tvalid/tready/tdata/tlast/tdest/tid)
//   noc_o_valid      one-hot flit valid per VC (registered)
//   noc_o_packet     flit contents (registered)
//   noc_i_credit     credit-return pulse per VC
//   err_bad_dest     sticky: packet dropped for out-of-range tdest
//   err_credit_ovf   sticky: credit returned to a full counter
module axis_noc_tx_bridge
    import axis_noc_tx_bridge_pkg::*;
#(
    parameter int D_W           = DEFAULT_D_W,
    parameter int A_W           = DEFAULT_A_W,
    parameter int VC_W          = DEFAULT_VC_W,
    parameter int TDEST_W       = DEFAULT_TDEST_W,
    parameter int TID_W         = DEFAULT_TID_W,
    parameter int VC_FIFO_DEPTH = DEFAULT_VC_FIFO_DEPTH,
    parameter int VC_COUNTER_W  = $clog2(VC_FIFO_DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic [D_W-1:0]     s_axis_tdata,
    input  logic               s_axis_tlast,
    input  logic [TDEST_W-1:0] s_axis_tdest,
    input  logic [TID_W-1:0]   s_axis_tid,
    output logic [VC_W-1:0]    noc_o_valid,
    output logic [D_W+A_W:0]   noc_o_packet,
    input  logic [VC_W-1:0]    noc_i_credit,
    output logic               err_bad_dest,
    output logic               err_credit_ovf
);

    localparam int SEL_W = vc_sel_width(VC_W);

    typedef struct packed {
        logic [D_W-1:0] data;
        logic           last;
    } payload_t;

    typedef struct packed {
        logic [A_W-1:0] addr;
    } routeinfo_t;

    typedef struct packed {
        payload_t   payload;
        routeinfo_t routeinfo;
    } packet_t;

    bridge_state_e   state_q, state_d;
    logic [SEL_W-1:0] vc_q, vc_in, cur_vc;
    logic [A_W-1:0]   addr_q;
    logic             bad_dest, credit_ok, send, set_bad, latch;
    logic [VC_W-1:0]  credit_nz, credit_ovf, dec_vec;
    packet_t          pkt_d, pkt_q;
    logic [VC_W-1:0]  valid_q;
    logic             bad_q;
    logic             unused_tid;

    assign unused_tid = ^s_axis_tid;

    generate
        if (VC_W > 1) begin : g_vc_sel
            assign vc_in = s_axis_tid[SEL_W-1:0];
        end else begin : g_vc_single
            assign vc_in = '0;
        end
        if (TDEST_W > A_W) begin : g_dest_chk
            assign bad_dest = |s_axis_tdest[TDEST_W-1:A_W];
        end else begin : g_dest_ok
            assign bad_dest = 1'b0;
        end
    endgenerate

    // Mid-burst the VC is locked; tid only matters at packet start.
    assign cur_vc    = (state_q == ST_BURST) ? vc_q : vc_in;
    assign credit_ok = credit_nz[cur_vc];

    always_comb begin
        state_d       = state_q;
        s_axis_tready = 1'b0;
        send          = 1'b0;
        set_bad       = 1'b0;
        latch         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bad_dest) begin
                    s_axis_tready = 1'b1;
                    if (s_axis_tvalid) begin
                        set_bad = 1'b1;
                        if (!s_axis_tlast) state_d = ST_DROP;
                    end
                end else begin
                    s_axis_tready = credit_ok;
                    if (s_axis_tvalid && credit_ok) begin
                        send  = 1'b1;
                        latch = 1'b1;
                        if (!s_axis_tlast) state_d = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                s_axis_tready = credit_ok;
                if (s_axis_tvalid && credit_ok) begin
                    send = 1'b1;
                    if (s_axis_tlast) state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pkt_d                = '0;
        pkt_d.payload.data   = s_axis_tdata;
        pkt_d.payload.last   = s_axis_tlast;
        pkt_d.routeinfo.addr = (state_q == ST_BURST) ? addr_q : s_axis_tdest[A_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vc_q    <= '0;
            addr_q  <= '0;
            valid_q <= '0;
            pkt_q   <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                vc_q   <= vc_in;
                addr_q <= s_axis_tdest[A_W-1:0];
            end
            valid_q <= send ? (VC_W'(1) << cur_vc) : '0;
            pkt_q   <= send ? pkt_d : '0;
            if (set_bad) bad_q <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < VC_W; gi++) begin : g_credit
            assign dec_vec[gi] = send && (cur_vc == SEL_W'(gi));
            noc_credit_counter #(
                .DEPTH (VC_FIFO_DEPTH),
                .CW    (VC_COUNTER_W)
            ) u_credit (
                .clk     (clk),
                .rst_n   (rst_n),
                .inc     (noc_i_credit[gi]),
                .dec     (dec_vec[gi]),
                .nonzero (credit_nz[gi]),
                .ovf     (credit_ovf[gi])
            );
        end
    endgenerate

    assign noc_o_valid    = valid_q;
    assign noc_o_packet   = pkt_q;
    assign err_bad_dest   = bad_q;
    assign err_credit_ovf = |credit_ovf;

endmodule

// File: tb/tb_axis_noc_tx_bridge.sv
module tb_axis_noc_tx_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tlast = 1'b0;
    logic [7:0]  s_axis_tdest = '0;
    logic [7:0]  s_axis_tid = '0;
    logic [1:0]  noc_o_valid;
    logic [36:0] noc_o_packet;
    logic [1:0]  noc_i_credit = '0;
    logic        err_bad_dest;
    logic        err_credit_ovf;

    always #5 clk = ~clk;

    axis_noc_tx_bridge dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tdest   (s_axis_tdest),
        .s_axis_tid     (s_axis_tid),
        .noc_o_valid    (noc_o_valid),
        .noc_o_packet   (noc_o_packet),
        .noc_i_credit   (noc_i_credit),
        .err_bad_dest   (err_bad_dest),
        .err_credit_ovf (err_credit_ovf)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: packet-level view of the bridge.
    // m_in_pkt: inside a forwarded packet; m_dropping: inside a dropped packet.
    int          m_cred[2];
    bit          m_in_pkt, m_dropping;
    int          m_vc;
    logic [3:0]  m_addr;
    bit          m_bad, m_ovf;
    logic [1:0]  exp_valid;
    logic [36:0] exp_pkt;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cred[0]  = 63;
        m_cred[1]  = 63;
        m_in_pkt   = 1'b0;
        m_dropping = 1'b0;
        m_vc       = 0;
        m_addr     = '0;
        m_bad      = 1'b0;
        m_ovf      = 1'b0;
        exp_valid  = '0;
        exp_pkt    = '0;
    endtask

    // One cycle, entered and left on a falling edge.
    task automatic step(input bit v, input logic [31:0] d, input bit l,
                        input logic [7:0] dest, input logic [7:0] tid, input logic [1:0] cr);
        bit exp_ready, bad, acc, sent;
        int vc;
        chk_eq("noc_o_valid", 64'(noc_o_valid), 64'(exp_valid));
        chk_eq("noc_o_packet", 64'(noc_o_packet), 64'(exp_pkt));
        chk_eq("err_bad_dest", 64'(err_bad_dest), 64'(m_bad));
        chk_eq("err_credit_ovf", 64'(err_credit_ovf), 64'(m_ovf));
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tdest  = dest;
        s_axis_tid    = tid;
        noc_i_credit  = cr;
        #1;
        bad = (dest > 8'd15);
        if (m_dropping) begin
            vc = m_vc;
            exp_ready = 1'b1;
        end else if (m_in_pkt) begin
            vc = m_vc;
            exp_ready = (m_cred[vc] > 0);
        end else begin
            vc = int'(tid[0]);
            exp_ready = bad ? 1'b1 : (m_cred[vc] > 0);
        end
        chk_eq("s_axis_tready", 64'(s_axis_tready), 64'(exp_ready));
        acc  = v && exp_ready;
        sent = 1'b0;
        if (acc) begin
            if (m_dropping) begin
                if (l) m_dropping = 1'b0;
            end else if (m_in_pkt) begin
                sent = 1'b1;
                if (l) m_in_pkt = 1'b0;
            end else if (bad) begin
                m_bad = 1'b1;
                if (!l) m_dropping = 1'b1;
            end else begin
                sent   = 1'b1;
                m_vc   = vc;
                m_addr = dest[3:0];
                if (!l) m_in_pkt = 1'b1;
            end
        end
        for (int i = 0; i < 2; i++) begin
            bit s;
            s = sent && (vc == i);
            if (cr[i] && !s) begin
                if (m_cred[i] == 63) m_ovf = 1'b1;
                else m_cred[i]++;
            end else if (s && !cr[i]) begin
                m_cred[i]--;
            end
        end
        exp_valid = sent ? 2'(1 << vc) : 2'b00;
        exp_pkt   = sent ? {d, l, m_addr} : 37'd0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_step(input logic [1:0] cr);
        step(1'b0, 32'd0, 1'b0, 8'd0, 8'd0, cr);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        s_axis_tvalid = 1'b0;
        noc_i_credit  = '0;
        #1;
        chk_eq("rst_valid", 64'(noc_o_valid), 64'd0);
        chk_eq("rst_packet", 64'(noc_o_packet), 64'd0);
        chk_eq("rst_err_bad", 64'(err_bad_dest), 64'd0);
        chk_eq("rst_err_ovf", 64'(err_credit_ovf), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk_eq("reset_valid", 64'(noc_o_valid), 64'd0);
        chk_eq("reset_packet", 64'(noc_o_packet), 64'd0);
        rst_n = 1'b1;

        // Single beat on VC1.
        step(1'b1, 32'hDEADBEEF, 1'b1, 8'd3, 8'd1, 2'b00);
        chk_eq("t1_valid", 64'(noc_o_valid), 64'(2'b10));
        chk_eq("t1_packet", 64'(noc_o_packet), 64'({32'hDEADBEEF, 1'b1, 4'd3}));

        // 4-beat packet: VC and addr locked from beat 0.
        step(1'b1, 32'hA0, 1'b0, 8'd5, 8'd0, 2'b00);
        step(1'b1, 32'hA1, 1'b0, 8'd7, 8'd1, 2'b00);
        step(1'b1, 32'hA2, 1'b0, 8'd9, 8'd1, 2'b00);
        step(1'b1, 32'hA3, 1'b1, 8'd2, 8'd1, 2'b00);
        chk_eq("t2_last_valid", 64'(noc_o_valid), 64'(2'b01));
        chk_eq("t2_last_packet", 64'(noc_o_packet), 64'({32'hA3, 1'b1, 4'd5}));
        idle_step(2'b00);

        // Exhaust VC1, then a single credit buys exactly one beat.
        do_reset();
        for (int i = 0; i < 63; i++) step(1'b1, 32'(i), 1'b1, 8'd3, 8'd1, 2'b00);
        step(1'b1, 32'h64, 1'b1, 8'd3, 8'd1, 2'b00);
        idle_step(2'b10);
        step(1'b1, 32'h65, 1'b1, 8'd3, 8'd1, 2'b00);
        step(1'b1, 32'h66, 1'b1, 8'd3, 8'd1, 2'b00);

        // Bad destination packet dropped, then a good one forwarded.
        do_reset();
        step(1'b1, 32'h1, 1'b0, 8'h10, 8'd0, 2'b00);
        step(1'b1, 32'h2, 1'b0, 8'h10, 8'd0, 2'b00);
        step(1'b1, 32'h3, 1'b1, 8'h10, 8'd0, 2'b00);
        step(1'b1, 32'h4, 1'b1, 8'h02, 8'd0, 2'b00);
        chk_eq("t4_err_bad", 64'(err_bad_dest), 64'd1);
        chk_eq("t4_good_valid", 64'(noc_o_valid), 64'(2'b01));
        idle_step(2'b00);

        // Simultaneous credit and send, drain VC0, refill and overflow.
        do_reset();
        step(1'b1, 32'h10, 1'b1, 8'd1, 8'd0, 2'b00);
        step(1'b1, 32'h11, 1'b1, 8'd1, 8'd0, 2'b01);
        for (int i = 0; i < 62; i++) step(1'b1, 32'(i), 1'b1, 8'd1, 8'd0, 2'b00);
        step(1'b1, 32'h12, 1'b1, 8'd1, 8'd0, 2'b00);
        for (int i = 0; i < 63; i++) idle_step(2'b01);
        chk_eq("t5_no_ovf", 64'(err_credit_ovf), 64'd0);
        idle_step(2'b01);
        chk_eq("t5_ovf", 64'(err_credit_ovf), 64'd1);
        idle_step(2'b00);

        // Reset mid-burst: remainder becomes a new packet on the current tid.
        do_reset();
        step(1'b1, 32'h20, 1'b0, 8'd4, 8'd0, 2'b00);
        step(1'b1, 32'h21, 1'b0, 8'd4, 8'd0, 2'b00);
        do_reset();
        step(1'b1, 32'h22, 1'b0, 8'd6, 8'd1, 2'b00);
        chk_eq("t6_new_vc", 64'(noc_o_valid), 64'(2'b10));
        step(1'b1, 32'h23, 1'b1, 8'd9, 8'd0, 2'b00);
        idle_step(2'b00);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] dest;
            logic [1:0] cr;
            if ($urandom_range(0, 7) == 0)
                dest = {4'($urandom_range(1, 15)), 4'($urandom)};
            else
                dest = {4'h0, 4'($urandom)};
            for (int i = 0; i < 2; i++) begin
                if (m_cred[i] < 63) cr[i] = ($urandom_range(0, 2) == 0);
                else                cr[i] = ($urandom_range(0, 40) == 0);
            end
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
                 dest, 8'($urandom), cr);
        end
        idle_step(2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_noc_tx_bridge.md
# axis_noc_tx_bridge

Ingress bridge from an AXI-Stream master into a NoC client port. It packs each AXIS beat into one NoC flit whose payload is data/last and whose routeinfo is the destination address, and steers it onto a virtual channel. Credit-based backpressure prevents overflow of the downstream per-VC RX FIFOs. It sits between a client's AXIS source and the router/noc_pipe input that consumes packed flits.

## Interface
- D_W, DEFAULT_D_W (32): flit data width; equals AXIS tdata width.
- A_W, DEFAULT_A_W (4): destination address width.
- VC_W, DEFAULT_VC_W (2): number of VCs, one valid bit per VC; power of two, ≥1.
- TDEST_W, DEFAULT_TDEST_W (8): AXIS tdest width; ≥ A_W.
- TID_W, DEFAULT_TID_W (8): AXIS tid width; ≥ max(1, $clog2(VC_W)).
- VC_FIFO_DEPTH, DEFAULT_VC_FIFO_DEPTH (64): downstream FIFO entries + 1.
- VC_COUNTER_W, $clog2(VC_FIFO_DEPTH): credit counter width.

Ports:
- clk  in  1  the single clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tvalid  in  1  AXIS beat valid.
- s_axis_tready  out  1  AXIS beat accept.
- s_axis_tdata  in  D_W  beat data.
- s_axis_tlast  in  1  last beat of packet.
- s_axis_tdest  in  TDEST_W  destination client.
- s_axis_tid  in  TID_W  low $clog2(VC_W) bits select the VC.
- noc_o_valid  out  VC_W  one-hot flit valid, bit = VC.
- noc_o_packet  out  D_W+1+A_W  {data, last, addr} in noc_packet_s order.
- noc_i_credit  in  VC_W  one-cycle credit-return pulse per VC.
- err_bad_dest  out  1  sticky; set when a packet is dropped for a bad destination.
- err_credit_ovf  out  1  sticky; set when a credit returns to a full counter.

## Operation
- FSM states IDLE, BURST, DROP; reset → IDLE.
- IDLE: vc = s_axis_tid[$clog2(VC_W)-1:0] (0 when VC_W=1). If tdest[TDEST_W-1:A_W] ≠ 0, the destination is bad: tready=1, the beat is discarded, err_bad_dest is set, and the FSM goes to DROP unless tlast. Otherwise tready = (credit[vc] ≠ 0). On accept, latch vc and addr = tdest[A_W-1:0]. Go to BURST if !tlast, else stay in IDLE.
- BURST: tid and tdest are ignored; the latched vc/addr are used. tready = (credit[latched vc] ≠ 0). Return to IDLE on an accepted tlast beat.
- DROP: tready=1 and no flits are emitted. Return to IDLE on an accepted tlast beat.
- Credits: one counter per VC, reset to VC_FIFO_DEPTH-1.
  - −1 on each flit sent on that VC.
  - +1 on each noc_i_credit pulse for that VC.
  - Both in the same cycle: the counter is unchanged.
  - A credit pulse while the counter is at VC_FIFO_DEPTH-1 with no send saturates the counter and sets err_credit_ovf.
  - The counter never underflows, because tready is gated by a nonzero count.
- tready may depend combinationally on tvalid/tid/tdest (AXIS-legal). No combinational path exists from noc_i_credit to tready; the registered count is used.

## Timing
- Output registered: a beat accepted at edge k drives noc_o_valid[vc]=1 and noc_o_packet for cycle k+1 only. There is no downstream ready; the flit is consumed unconditionally.
- Throughput: 1 beat/cycle while credits remain. A credit returned at edge k is usable for acceptance at edge k+1.
- The credit decrement happens at the acceptance edge, not at the output edge.
- Reset values:
  - noc_o_valid=0 and noc_o_packet=0.
  - err flags=0, FSM=IDLE.
  - s_axis_tready follows from state; all credits full, so tready=1 for a good destination.
- Reset mid-packet: the remaining beats of that packet are treated as a new packet (VC taken from tid, destination checked).
- The err flags clear only on reset.

## Structure
- Flit layout comes from the shared package's noc_payload_s / noc_routeinfo_s / noc_packet_s, rebuilt locally when widths differ from the defaults. Add an FSM state enum typedef and a helper constant VC_SEL_W = (VC_W>1) ? $clog2(VC_W) : 1 to the common package.
- One sub-module: noc_credit_counter (single VC counter with inc/dec/saturate/overflow flag), instantiated VC_W times in a generate loop.

## Test plan
- Reset, single beat tdata=0xDEADBEEF, tlast=1, tdest=3, tid=1 → next cycle noc_o_valid=2'b10, packet={0xDEADBEEF,1,4'd3}; credit[1]=62.
- 4-beat packet, tid=0 on beat 0 and tid=1 on beats 1-3, tdest varying → all 4 flits on VC0 with addr from beat 0; back-to-back output, no bubbles.
- 63 beats on VC1 with no credit returns → tready=0 on the 64th. Pulse noc_i_credit[1] once → exactly one more beat is accepted one cycle later.
- tdest=8'h10 (bad for A_W=4), 3-beat packet → tready=1 throughout, no noc_o_valid, err_bad_dest=1. The next good packet is forwarded normally.
- Credit pulse and send on the same VC in one cycle → count unchanged. Credit pulse on a full VC0 → count stays 63, err_credit_ovf=1.
- Assert rst_n low mid-BURST → outputs 0, credits 63 next edge. The remaining beats are treated as a new packet, with VC from the current tid.
